// File: rtl/mac_sequencer_if.sv
// Bundles the operand, MAC-side and result channels of the MAC sequencer.
// The slave modport is the sequencer view; master is the driver/consumer view.
interface mac_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             op_valid;
   logic             op_ready;
   logic [15:0]      op_value;
   logic [15:0]      op_weight;
   logic             op_last;
   logic [15:0]      init_acc;

   logic             mac_start;
   logic [15:0]      mac_in_value;
   logic [15:0]      mac_weight;
   logic [15:0]      mac_in_accumulate;
   logic [15:0]      mac_out_accumulate;

   logic             res_valid;
   logic             res_ready;
   logic [15:0]      res_data;
   logic             res_ovf;
   logic [CNT_W-1:0] res_count;

   modport slave (
      input  op_valid, op_value, op_weight, op_last, init_acc,
      input  mac_out_accumulate, res_ready,
      output op_ready, mac_start, mac_in_value, mac_weight, mac_in_accumulate,
      output res_valid, res_data, res_ovf, res_count
   );

   modport master (
      output op_valid, op_value, op_weight, op_last, init_acc,
      output mac_out_accumulate, res_ready,
      input  op_ready, mac_start, mac_in_value, mac_weight, mac_in_accumulate,
      input  res_valid, res_data, res_ovf, res_count
   );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences fp16 operand pairs through an external fixed-latency MAC unit,
// chaining the running accumulator into each issue and presenting the final
// dot product together with an element count and a sticky overflow flag.
module mac_sequencer #(
   parameter int MAC_LAT = 3,
   parameter int CNT_W   = 8
) (
   input logic           clk,
   input logic           nRST,
   mac_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0]  LAST_WAIT = 4'(MAC_LAT - 1);
   localparam logic [15:0] FP16_INF  = 16'h7C00;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic             first;
   logic             last_q;
   logic [15:0]      value_q;
   logic [15:0]      weight_q;
   logic [15:0]      acc;
   logic             ovf;
   logic [CNT_W-1:0] count;
   logic             op_ready_q;
   logic             mac_start_q;
   logic             res_valid_q;

   // The accumulator feeds both the next MAC issue and the result channel.
   assign bus.op_ready          = op_ready_q;
   assign bus.mac_start         = mac_start_q;
   assign bus.mac_in_value      = value_q;
   assign bus.mac_weight        = weight_q;
   assign bus.mac_in_accumulate = acc;
   assign bus.res_valid         = res_valid_q;
   assign bus.res_data          = acc;
   assign bus.res_ovf           = ovf;
   assign bus.res_count         = count;

   // Sequencer FSM: accept a pair, pulse start, wait out the MAC latency,
   // capture the partial sum, then either take the next pair or hold the result.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state       <= IDLE;
         wait_cnt    <= 4'd0;
         first       <= 1'b1;
         last_q      <= 1'b0;
         value_q     <= 16'h0000;
         weight_q    <= 16'h0000;
         acc         <= 16'h0000;
         ovf         <= 1'b0;
         count       <= '0;
         op_ready_q  <= 1'b1;
         mac_start_q <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.op_valid && op_ready_q) begin
                  value_q     <= bus.op_value;
                  weight_q    <= bus.op_weight;
                  last_q      <= bus.op_last;
                  if (first) begin
                     acc <= bus.init_acc;
                  end
                  op_ready_q  <= 1'b0;
                  mac_start_q <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               mac_start_q <= 1'b0;
               wait_cnt    <= 4'd0;
               state       <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == LAST_WAIT) begin
                  acc <= bus.mac_out_accumulate;
                  if (count != '1) begin
                     count <= count + 1'b1;
                  end
                  if (bus.mac_out_accumulate == FP16_INF) begin
                     ovf <= 1'b1;
                  end
                  if (last_q) begin
                     res_valid_q <= 1'b1;
                     state       <= DONE;
                  end else begin
                     first      <= 1'b0;
                     op_ready_q <= 1'b1;
                     state      <= IDLE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  first       <= 1'b1;
                  count       <= '0;
                  ovf         <= 1'b0;
                  res_valid_q <= 1'b0;
                  op_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a MAC_LAT=3 and a MAC_LAT=1 instance share
// one stimulus path selected by 'sel'; expected dot-product results are queued
// when the closing pair is driven and popped when the result appears.
module tb_mac_sequencer;

   logic clk = 1'b0;
   logic nRST;
   logic sel = 1'b0;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   logic        op_valid_d;
   logic [15:0] op_value_d;
   logic [15:0] op_weight_d;
   logic        op_last_d;
   logic [15:0] init_acc_d;
   logic [15:0] mac_out_d;
   logic        res_ready_d;

   mac_sequencer_if #(.CNT_W(8)) bus3 ();
   mac_sequencer_if #(.CNT_W(8)) bus1 ();

   mac_sequencer #(.MAC_LAT(3), .CNT_W(8)) dut3 (.clk(clk), .nRST(nRST), .bus(bus3.slave));
   mac_sequencer #(.MAC_LAT(1), .CNT_W(8)) dut1 (.clk(clk), .nRST(nRST), .bus(bus1.slave));

   assign bus3.op_valid           = !sel && op_valid_d;
   assign bus1.op_valid           = sel && op_valid_d;
   assign bus3.res_ready          = !sel && res_ready_d;
   assign bus1.res_ready          = sel && res_ready_d;
   assign bus3.op_value           = op_value_d;
   assign bus1.op_value           = op_value_d;
   assign bus3.op_weight          = op_weight_d;
   assign bus1.op_weight          = op_weight_d;
   assign bus3.op_last            = op_last_d;
   assign bus1.op_last            = op_last_d;
   assign bus3.init_acc           = init_acc_d;
   assign bus1.init_acc           = init_acc_d;
   assign bus3.mac_out_accumulate = mac_out_d;
   assign bus1.mac_out_accumulate = mac_out_d;

   logic        dut_op_ready, dut_mac_start, dut_res_valid, dut_res_ovf;
   logic [15:0] dut_mac_in_value, dut_mac_weight, dut_mac_in_acc, dut_res_data;
   logic [7:0]  dut_res_count;

   assign dut_op_ready     = sel ? bus1.op_ready          : bus3.op_ready;
   assign dut_mac_start    = sel ? bus1.mac_start         : bus3.mac_start;
   assign dut_mac_in_value = sel ? bus1.mac_in_value      : bus3.mac_in_value;
   assign dut_mac_weight   = sel ? bus1.mac_weight        : bus3.mac_weight;
   assign dut_mac_in_acc   = sel ? bus1.mac_in_accumulate : bus3.mac_in_accumulate;
   assign dut_res_valid    = sel ? bus1.res_valid         : bus3.res_valid;
   assign dut_res_data     = sel ? bus1.res_data          : bus3.res_data;
   assign dut_res_ovf      = sel ? bus1.res_ovf           : bus3.res_ovf;
   assign dut_res_count    = sel ? bus1.res_count         : bus3.res_count;

   typedef struct {
      logic [15:0] data;
      logic [7:0]  count;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   // Hard stop in case the sequence stalls somewhere unbounded.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_op_ready"},  32'(dut_op_ready), 32'd1);
      check_output({tag, "_mac_start"}, 32'(dut_mac_start), 32'd0);
      check_output({tag, "_mac_value"}, 32'(dut_mac_in_value), 32'd0);
      check_output({tag, "_mac_weight"}, 32'(dut_mac_weight), 32'd0);
      check_output({tag, "_mac_acc"},   32'(dut_mac_in_acc), 32'd0);
      check_output({tag, "_res_valid"}, 32'(dut_res_valid), 32'd0);
      check_output({tag, "_res_data"},  32'(dut_res_data), 32'd0);
      check_output({tag, "_res_ovf"},   32'(dut_res_ovf), 32'd0);
      check_output({tag, "_res_count"}, 32'(dut_res_count), 32'd0);
   endtask

   // Drives one pair through a full element period; the MAC stub answers 'stub'.
   task automatic apply_stimulus(input logic [15:0] v, input logic [15:0] w,
                                 input logic [15:0] init, input logic [15:0] stub,
                                 input logic last, input logic [15:0] exp_acc);
      int lat_now;
      int guard;
      lat_now = sel ? 1 : 3;
      guard   = 0;
      while (dut_op_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      check_output("op_ready_wait", 32'(dut_op_ready), 32'd1);
      op_valid_d  = 1'b1;
      op_value_d  = v;
      op_weight_d = w;
      op_last_d   = last;
      init_acc_d  = init;
      mac_out_d   = stub;
      tick();
      op_valid_d  = 1'b0;
      check_output("issue_start",  32'(dut_mac_start), 32'd1);
      check_output("issue_value",  32'(dut_mac_in_value), 32'(v));
      check_output("issue_weight", 32'(dut_mac_weight), 32'(w));
      check_output("issue_acc",    32'(dut_mac_in_acc), 32'(exp_acc));
      check_output("issue_ready",  32'(dut_op_ready), 32'd0);
      for (int i = 0; i < lat_now; i++) begin
         tick();
         check_output("wait_start", 32'(dut_mac_start), 32'd0);
         check_output("wait_ready", 32'(dut_op_ready), 32'd0);
         check_output("wait_valid", 32'(dut_res_valid), 32'd0);
         check_output("wait_value", 32'(dut_mac_in_value), 32'(v));
         check_output("wait_acc",   32'(dut_mac_in_acc), 32'(exp_acc));
      end
      tick();
      if (last) check_output("done_res_valid", 32'(dut_res_valid), 32'd1);
      else      check_output("next_op_ready", 32'(dut_op_ready), 32'd1);
      check_output("post_start", 32'(dut_mac_start), 32'd0);
   endtask

   // Pops the expected result, holds off the consumer for 'hold' cycles while
   // poking op_valid, then completes the result handshake.
   task automatic take_result(input int hold, input logic [15:0] last_v);
      exp_t e;
      e.data  = 16'h0000;
      e.count = 8'h00;
      e.ovf   = 1'b0;
      check_output("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      check_output("res_valid", 32'(dut_res_valid), 32'd1);
      check_output("res_data",  32'(dut_res_data), 32'(e.data));
      check_output("res_count", 32'(dut_res_count), 32'(e.count));
      check_output("res_ovf",   32'(dut_res_ovf), 32'(e.ovf));
      res_ready_d = 1'b0;
      op_valid_d  = 1'b1;
      op_value_d  = 16'hDEAD;
      op_last_d   = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick();
         check_output("hold_valid", 32'(dut_res_valid), 32'd1);
         check_output("hold_data",  32'(dut_res_data), 32'(e.data));
         check_output("hold_count", 32'(dut_res_count), 32'(e.count));
         check_output("hold_ovf",   32'(dut_res_ovf), 32'(e.ovf));
         check_output("hold_ready", 32'(dut_op_ready), 32'd0);
         check_output("hold_start", 32'(dut_mac_start), 32'd0);
      end
      op_valid_d  = 1'b0;
      res_ready_d = 1'b1;
      tick();
      res_ready_d = 1'b0;
      check_output("rel_valid", 32'(dut_res_valid), 32'd0);
      check_output("rel_ready", 32'(dut_op_ready), 32'd1);
      check_output("rel_count", 32'(dut_res_count), 32'd0);
      check_output("rel_ovf",   32'(dut_res_ovf), 32'd0);
      check_output("rel_value_kept", 32'(dut_mac_in_value), 32'(last_v));
   endtask

   // Directed sequence: reset, single pair, chained pairs with backpressure,
   // overflow, mid-WAIT reset, then the MAC_LAT=1 instance incl. count saturation.
   initial begin
      logic [15:0] stub_prev;
      nRST        = 1'b0;
      op_valid_d  = 1'b0;
      op_value_d  = 16'h0000;
      op_weight_d = 16'h0000;
      op_last_d   = 1'b0;
      init_acc_d  = 16'h0000;
      mac_out_d   = 16'h0000;
      res_ready_d = 1'b0;
      #12;
      check_reset_state("in_reset");
      tick();
      nRST = 1'b1;
      tick();
      check_reset_state("after_reset");

      $display("[TB] single pair");
      sb.push_back('{data: 16'h4700, count: 8'd1, ovf: 1'b0});
      apply_stimulus(16'h4000, 16'h4200, 16'h3C00, 16'h4700, 1'b1, 16'h3C00);
      take_result(0, 16'h4000);

      $display("[TB] three pairs with backpressure");
      apply_stimulus(16'h3400, 16'h3500, 16'h3800, 16'h4000, 1'b0, 16'h3800);
      apply_stimulus(16'h3600, 16'h3700, 16'h1234, 16'h4400, 1'b0, 16'h4000);
      sb.push_back('{data: 16'h4600, count: 8'd3, ovf: 1'b0});
      apply_stimulus(16'h3A00, 16'h3B00, 16'h1234, 16'h4600, 1'b1, 16'h4400);
      take_result(10, 16'h3A00);

      $display("[TB] overflow");
      apply_stimulus(16'h7000, 16'h7000, 16'h0000, 16'h7C00, 1'b0, 16'h0000);
      sb.push_back('{data: 16'h3C00, count: 8'd2, ovf: 1'b1});
      apply_stimulus(16'h0001, 16'h0002, 16'h0000, 16'h3C00, 1'b1, 16'h7C00);
      take_result(2, 16'h0001);

      $display("[TB] reset mid-WAIT");
      apply_stimulus(16'h1010, 16'h2020, 16'h1111, 16'h2222, 1'b0, 16'h1111);
      op_valid_d  = 1'b1;
      op_value_d  = 16'h3030;
      op_weight_d = 16'h4040;
      op_last_d   = 1'b1;
      mac_out_d   = 16'h3333;
      tick();
      op_valid_d  = 1'b0;
      tick();
      tick();
      nRST = 1'b0;
      #1;
      check_reset_state("mid_wait_reset");
      tick();
      nRST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_output("no_stale_result", 32'(dut_res_valid), 32'd0);
      end
      sb.push_back('{data: 16'h5555, count: 8'd1, ovf: 1'b0});
      apply_stimulus(16'h3E00, 16'h3F00, 16'h3A00, 16'h5555, 1'b1, 16'h3A00);
      take_result(0, 16'h3E00);

      $display("[TB] MAC_LAT=1 instance");
      sel = 1'b1;
      tick();
      apply_stimulus(16'h2000, 16'h2100, 16'h0400, 16'h4100, 1'b0, 16'h0400);
      sb.push_back('{data: 16'h4200, count: 8'd2, ovf: 1'b0});
      apply_stimulus(16'h2200, 16'h2300, 16'h0000, 16'h4200, 1'b1, 16'h4100);
      take_result(3, 16'h2200);

      $display("[TB] count saturation");
      stub_prev = 16'h0800;
      for (int i = 0; i < 260; i++) begin
         if (i == 259) sb.push_back('{data: 16'(i + 1), count: 8'd255, ovf: 1'b0});
         apply_stimulus(16'(i), 16'h0100, 16'h0800, 16'(i + 1), (i == 259), stub_prev);
         stub_prev = 16'(i + 1);
      end
      take_result(1, 16'd259);

      check_output("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
